// File: rtl/sram_pattern_tester_if.sv
// sram_pattern_tester_if: request/busy bus between the pattern tester and the SPI-SRAM encoder.
interface sram_pattern_tester_if #(
   parameter int WORD_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 16
);
   logic                     mem_initialized;
   logic                     mem_busy;
   logic [WORD_WIDTH-1:0]    mem_rdata;
   logic                     mem_request;
   logic                     mem_write;
   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic [WORD_WIDTH-1:0]    mem_wdata;
   modport master(
      input  mem_initialized, mem_busy, mem_rdata,
      output mem_request, mem_write, mem_address, mem_wdata
   );
   modport slave(
      output mem_initialized, mem_busy, mem_rdata,
      input  mem_request, mem_write, mem_address, mem_wdata
   );
endinterface

// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester: fills an SRAM window with a pattern, reads it back and counts mismatches.
// Define SRAM_TESTER_STOP_ON_ERROR_EN to end the run at the first mismatch.
module sram_pattern_tester #(
   parameter int WORD_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 16,
   parameter int WORD_COUNT    = 8192,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic                     bulk,
   input  logic [WORD_WIDTH-1:0]    seed,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   sram_pattern_tester_if.master    mem,
   output logic                     owns_sram,
   output logic                     running,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] error_count,
   output logic [ADDRESS_WIDTH-1:0] first_err_addr
);
   localparam int IW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORD_COUNT - 1);

   typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE} state_t;

   state_t                   state_q, state_d;
   logic [1:0]               mode_q, mode_d;
   logic                     bulk_q, bulk_d;
   logic [WORD_WIDTH-1:0]    seed_q, seed_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [WORD_WIDTH-1:0]    rdata_q, rdata_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
   logic [ADDRESS_WIDTH-1:0] first_q, first_d;
   logic                     done_q, done_d;
   logic                     pass_q, pass_d;
   logic                     running_q, running_d;
   logic                     owns_q, owns_d;

   logic [ADDRESS_WIDTH-1:0] addr;
   logic [WORD_WIDTH-1:0]    addr_w, walk, pattern;
   logic                     wr, rd, mismatch, last_check;

   assign addr     = base_q + ADDRESS_WIDTH'(idx_q);
   assign addr_w   = WORD_WIDTH'(addr);
   assign walk     = WORD_WIDTH'(1) << (idx_q % WORD_WIDTH);
   assign pattern  = mode_q == 2'd0 ? (idx_q[0] ? ~seed_q : seed_q) :
                     mode_q == 2'd1 ? addr_w ^ seed_q :
                     mode_q == 2'd2 ? walk ^ seed_q : ~addr_w ^ seed_q;
   assign mismatch = rdata_q != pattern;
`ifdef SRAM_TESTER_STOP_ON_ERROR_EN
   assign last_check = idx_q == LAST || mismatch;
`else
   assign last_check = idx_q == LAST;
`endif

   assign wr = state_q == WR_REQ || state_q == WR_WAIT;
   assign rd = state_q == RD_REQ || state_q == RD_WAIT;
   // request drops combinationally in the cycle busy is seen low, ending the transaction
   assign mem.mem_request = state_q == WR_REQ || state_q == RD_REQ ||
                            ((state_q == WR_WAIT || state_q == RD_WAIT) && mem.mem_busy);
   assign mem.mem_write   = wr;
   assign mem.mem_address = wr || rd ? addr : '0;
   assign mem.mem_wdata   = wr ? pattern : '0;

   assign owns_sram      = owns_q;
   assign running        = running_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign error_count    = err_q;
   assign first_err_addr = first_q;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      bulk_d    = bulk_q;
      seed_d    = seed_q;
      base_d    = base_q;
      idx_d     = idx_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      first_d   = first_q;
      done_d    = done_q;
      pass_d    = pass_q;
      running_d = running_q;
      owns_d    = owns_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d   = WAIT_INIT;
            mode_d    = mode;
            bulk_d    = bulk;
            seed_d    = seed;
            base_d    = base_addr;
            idx_d     = '0;
            err_d     = '0;
            first_d   = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            running_d = 1'b1;
            owns_d    = 1'b1;
         end
         WAIT_INIT: if (mem.mem_initialized) state_d = WR_REQ;
         WR_REQ:    if (mem.mem_busy) state_d = WR_WAIT;
         WR_WAIT: if (!mem.mem_busy) begin
            state_d = !bulk_q || idx_q == LAST ? RD_REQ : WR_REQ;
            idx_d   = !bulk_q ? idx_q : idx_q == LAST ? '0 : idx_q + 1'b1;
         end
         RD_REQ:    if (mem.mem_busy) state_d = RD_WAIT;
         RD_WAIT: if (!mem.mem_busy) begin
            state_d = CHECK;
            rdata_d = mem.mem_rdata;
         end
         CHECK: begin
            if (mismatch) begin
               err_d   = &err_q ? err_q : err_q + 1'b1;
               first_d = err_q == '0 ? addr : first_q;
            end
            if (last_check) begin
               state_d   = DONE;
               running_d = 1'b0;
               done_d    = 1'b1;
               pass_d    = err_d == '0;
               owns_d    = 1'b0;
            end else begin
               state_d = bulk_q ? RD_REQ : WR_REQ;
               idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         mode_q    <= '0;
         bulk_q    <= 1'b0;
         seed_q    <= '0;
         base_q    <= '0;
         idx_q     <= '0;
         rdata_q   <= '0;
         err_q     <= '0;
         first_q   <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         running_q <= 1'b0;
         owns_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         bulk_q    <= bulk_d;
         seed_q    <= seed_d;
         base_q    <= base_d;
         idx_q     <= idx_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         first_q   <= first_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         running_q <= running_d;
         owns_q    <= owns_d;
      end
   end
endmodule

// File: doc/sram_pattern_tester.md
# sram_pattern_tester

Parametrised SPI-SRAM self-test sequencer that sits between the `spi_sram_encoder` request/busy port and the video path. It fills a configurable address window with one of four data patterns and reads every word back, counting mismatches. It supports both interleaved (write/read per word) and bulk (write all, then read all) ordering. On completion it releases SRAM ownership so the top level can mux the bus to the video RAM reader.

## Interface
- `WORD_WIDTH`, 16, data word width.
- `ADDRESS_WIDTH`, 16, SRAM word address width.
- `WORD_COUNT`, 8192, words tested per run; must be ≥1 and ≤2^ADDRESS_WIDTH.
- `ERR_CNT_WIDTH`, 8, error counter width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle pulse that starts a run.
- `mode`  in  2  pattern select, sampled at start.
- `bulk`  in  1  0 = interleaved, 1 = bulk ordering; sampled at start.
- `seed`  in  WORD_WIDTH  pattern seed, sampled at start.
- `base_addr`  in  ADDRESS_WIDTH  first tested address, sampled at start.
- `mem_initialized`  in  1  encoder ready.
- `mem_busy`  in  1  encoder transaction in progress.
- `mem_rdata`  in  WORD_WIDTH  read data from encoder.
- `mem_request`  out  1  transaction request.
- `mem_write`  out  1  1 = write, 0 = read.
- `mem_address`  out  ADDRESS_WIDTH  transaction address.
- `mem_wdata`  out  WORD_WIDTH  write data.
- `owns_sram`  out  1  1 = encoder drives SRAM pins; 0 = video reader does.
- `running`  out  1  run in progress.
- `done`  out  1  run finished; held until next start.
- `pass`  out  1  valid with done; 1 when error_count == 0.
- `error_count`  out  ERR_CNT_WIDTH  mismatches, saturating.
- `first_err_addr`  out  ADDRESS_WIDTH  address of first mismatch.

## Operation
- States: IDLE, WAIT_INIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE.
- IDLE/DONE → WAIT_INIT on `start`. The transition latches mode, bulk, seed and base_addr, clears index, error_count and first_err_addr, clears done and pass, and sets running and owns_sram. `start` is ignored in every other state.
- WAIT_INIT → WR_REQ when `mem_initialized` is high.
- Address = base_addr + index, modulo 2^ADDRESS_WIDTH (wraps).
- Pattern p(i), where i is the index:
  - mode 0: seed when i is even, ~seed when i is odd.
  - mode 1: address XOR seed.
  - mode 2: (1 << (i mod WORD_WIDTH)) XOR seed.
  - mode 3: ~address XOR seed.
  - Address is zero-extended or truncated to WORD_WIDTH.
- Handshake, same for both request states:
  - In xx_REQ, drive address, data and write, then assert `mem_request`.
  - xx_REQ → xx_WAIT once `mem_busy` is seen high.
  - In xx_WAIT, `mem_busy` low ends the transaction: deassert `mem_request` the same cycle and, for reads, capture `mem_rdata`.
  - Address, write and wdata stay stable while `mem_request` is high.
- Interleaved ordering: WR_WAIT → RD_REQ at the same index → CHECK → next index, until `WORD_COUNT` is reached.
- Bulk ordering: WR_WAIT → WR_REQ for every index. After the last write, index resets to 0 and reads proceed RD_REQ → RD_WAIT → CHECK.
- CHECK compares captured data with p(i). On a mismatch:
  - error_count is incremented, saturating at all-ones.
  - first_err_addr is loaded if this is the first error.
- Last CHECK → DONE: running=0, done=1, pass=(error_count==0 after the update), owns_sram=0.

## Timing
- Reset values:
  - all mem_* outputs 0.
  - owns_sram 1.
  - running, done, pass 0.
  - error_count and first_err_addr 0.
  - State IDLE.
- Reset mid-run drops mem_request immediately (next edge) and returns to IDLE; the encoder is reset by the top level through its own path.
- start → WAIT_INIT in 1 cycle; first mem_request follows 1 cycle after mem_initialized is seen.
- CHECK takes exactly 1 cycle. No idle cycles beyond the handshake otherwise.
- mem_busy high in the same cycle as mem_request rising is accepted.
- mem_initialized falling during a run has no effect; the handshake alone governs progress.

## Configuration
- `SRAM_TESTER_STOP_ON_ERROR_EN`:
  - Defined: the first mismatch moves CHECK → DONE immediately, with error_count=1 and pass=0.
  - Undefined: the run always covers all `WORD_COUNT` words.

## Test plan
- WORD_COUNT=4, mode 0, seed=16'hFF00, interleaved, ideal memory model → write/read order W0 R0 W1 R1…; data FF00, 00FF, FF00, 00FF; done=1, pass=1, owns_sram=0.
- Same with bulk=1 → order W0 W1 W2 W3 R0 R1 R2 R3; pass=1.
- base_addr=16'hFFFE, WORD_COUNT=4, mode 1, seed=0 → addresses FFFE, FFFF, 0000, 0001 with data equal to address.
- Model corrupts the read at address 2, WORD_COUNT=8, macro undefined → error_count=1, first_err_addr=2, pass=0, all 8 reads issued. With the macro defined → DONE after the read at address 2, no further requests.
- Model corrupts every read, ERR_CNT_WIDTH=2, WORD_COUNT=8 → error_count saturates at 3.
- Assert reset while in WR_WAIT → next cycle mem_request=0, owns_sram=1, done=0. A subsequent start runs cleanly to pass=1.
